// File: rtl/iddr_align_pkg.sv
// Shared types and constants for the IDDR lane aligner.
// Holds the per-lane FSM state encoding and counter sizing helper.
package iddr_align_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StCheck,
        StSlip,
        StLocked,
        StFail
    } lane_state_e;

    localparam int unsigned DefaultSlipWait  = 8;
    localparam int unsigned DefaultLockCount = 16;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/iddr_align_lane.sv
// Single-lane training FSM: settle, compare against the training word,
// bit-slip on mismatch, and report lock or an exhausted slip budget.
module iddr_align_lane
    import iddr_align_pkg::*;
#(
    parameter int unsigned          RATIO         = 4,
    parameter logic [RATIO-1:0]     TRAIN_PATTERN = 4'hC,
    parameter int unsigned          SLIP_WAIT     = DefaultSlipWait,
    parameter int unsigned          LOCK_COUNT    = DefaultLockCount,
    parameter int unsigned          MAX_SLIPS     = 2 * RATIO,
    parameter int unsigned          SW            = cnt_width(MAX_SLIPS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ready_i,
    input  logic             train_i,
    input  logic             restart_i,
    input  logic [RATIO-1:0] word_i,
    output logic             alignwd_o,
    output logic             locked_o,
    output logic             fail_o,
    output logic [SW-1:0]    slip_count_o
);

    localparam int unsigned WaitW  = cnt_width(SLIP_WAIT);
    localparam int unsigned MatchW = cnt_width(LOCK_COUNT);

    localparam logic [WaitW-1:0]  WaitLast  = WaitW'(SLIP_WAIT - 1);
    localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_COUNT - 1);
    localparam logic [SW-1:0]     SlipMax   = SW'(MAX_SLIPS);

    lane_state_e       state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [MatchW-1:0] match_q, match_d;
    logic [SW-1:0]     slip_q, slip_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            wait_q  <= '0;
            match_q <= '0;
            slip_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            match_q <= match_d;
            slip_q  <= slip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        match_d = match_q;
        slip_d  = slip_q;
        if (!ready_i) begin
            state_d = StIdle;
            wait_d  = '0;
            match_d = '0;
            slip_d  = '0;
        end else if (restart_i) begin
            // A fresh training request overrides whatever the lane was doing.
            state_d = StWait;
            wait_d  = '0;
            match_d = '0;
            slip_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (train_i) begin
                        state_d = StWait;
                        wait_d  = '0;
                    end
                end
                StWait: begin
                    if (wait_q == WaitLast) begin
                        state_d = StCheck;
                        match_d = '0;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end
                StCheck: begin
                    if (word_i == TRAIN_PATTERN) begin
                        if (match_q == MatchLast) begin
                            state_d = StLocked;
                        end else begin
                            match_d = match_q + MatchW'(1);
                        end
                    end else if (slip_q == SlipMax) begin
                        state_d = StFail;
                    end else begin
                        state_d = StSlip;
                    end
                end
                StSlip: begin
                    if (slip_q != SlipMax) begin
                        slip_d = slip_q + SW'(1);
                    end
                    wait_d  = '0;
                    state_d = StWait;
                end
                StLocked, StFail: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign alignwd_o    = (state_q == StSlip);
    assign locked_o     = (state_q == StLocked);
    assign fail_o       = (state_q == StFail);
    assign slip_count_o = slip_q;

endmodule

// File: rtl/iddr_lane_aligner.sv
// Multi-lane IDDR word aligner: per-lane training FSMs plus the shared
// train_en edge detect, registered data path and data_valid generation.
module iddr_lane_aligner
    import iddr_align_pkg::*;
#(
    parameter int unsigned      CHANNELS      = 4,
    parameter int unsigned      RATIO         = 4,
    parameter logic [RATIO-1:0] TRAIN_PATTERN = 4'hC,
    parameter int unsigned      SLIP_WAIT     = DefaultSlipWait,
    parameter int unsigned      LOCK_COUNT    = DefaultLockCount,
    parameter int unsigned      MAX_SLIPS     = 2 * RATIO,
    localparam int unsigned     SW            = cnt_width(MAX_SLIPS)
) (
    input  logic                      sclk,
    input  logic                      reset_n,
    input  logic                      ready_in,
    input  logic                      train_en,
    input  logic [CHANNELS*RATIO-1:0] q_in,
    output logic [CHANNELS-1:0]       alignwd,
    output logic [CHANNELS*RATIO-1:0] data_out,
    output logic                      data_valid,
    output logic [CHANNELS-1:0]       locked,
    output logic [CHANNELS-1:0]       fail,
    output logic                      all_locked,
    output logic [CHANNELS*SW-1:0]    slip_count
);

    logic                      train_q;
    logic                      train_rise;
    logic [CHANNELS*RATIO-1:0] data_q;
    logic                      valid_q;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            train_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            train_q <= train_en;
            data_q  <= q_in;
            valid_q <= all_locked & ~train_en;
        end
    end

    assign train_rise = train_en & ~train_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        iddr_align_lane #(
            .RATIO         (RATIO),
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .SLIP_WAIT     (SLIP_WAIT),
            .LOCK_COUNT    (LOCK_COUNT),
            .MAX_SLIPS     (MAX_SLIPS),
            .SW            (SW)
        ) u_lane (
            .clk_i        (sclk),
            .rst_ni       (reset_n),
            .ready_i      (ready_in),
            .train_i      (train_en),
            .restart_i    (train_rise),
            .word_i       (q_in[i*RATIO +: RATIO]),
            .alignwd_o    (alignwd[i]),
            .locked_o     (locked[i]),
            .fail_o       (fail[i]),
            .slip_count_o (slip_count[i*SW +: SW])
        );
    end

    // AND of registered lock bits, so no extra cycle over locked.
    assign all_locked = &locked;
    assign data_out   = data_q;
    assign data_valid = valid_q;

endmodule

// File: doc/iddr_lane_aligner.md
# iddr_lane_aligner

Parametrised multi-lane word aligner for the x2/x4 IDDR gearbox path. Sits between the IDDR gearbox outputs (`q`, `ready`) and the fabric data consumer, all on `sclk`. Per lane it pulses `alignwd` (bit slip) until a training pattern is seen for a required number of consecutive words, then reports lock. Once every lane is locked it forwards aligned words with a valid flag. It generalises the single-lane 1:4 IDDR to CHANNELS lanes with an automatic training state machine, a slip budget and failure reporting.

## Interface
- CHANNELS, 4: number of IDDR lanes.
- RATIO, 4: bits per gearbox word (4 or 8).
- TRAIN_PATTERN, 4'hC: expected training word (RATIO bits).
- SLIP_WAIT, 8: settle cycles after each slip before comparing (≥1).
- LOCK_COUNT, 16: consecutive matches required for lock (≥1).
- MAX_SLIPS, 2*RATIO: slip budget before failure.
- sclk  in  1  gearbox slow clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ready_in  in  1  gearbox ready (IDDR `ready`).
- train_en  in  1  training request; a rising edge restarts training on all lanes.
- q_in  in  CHANNELS*RATIO  gearbox words; lane i is bits [i*RATIO +: RATIO].
- alignwd  out  CHANNELS  per-lane bit-slip pulse to the gearbox.
- data_out  out  CHANNELS*RATIO  registered copy of q_in.
- data_valid  out  1  all lanes locked and train_en low.
- locked  out  CHANNELS  per-lane lock.
- fail  out  CHANNELS  per-lane slip budget exhausted (sticky).
- all_locked  out  1  AND of locked.
- slip_count  out  CHANNELS*SW  per-lane slips issued; SW = $clog2(MAX_SLIPS+1).

## Operation
- Each lane has an independent registered FSM: IDLE, WAIT, CHECK, SLIP, LOCKED, FAIL.
- IDLE: counters at 0. Go to WAIT when ready_in && train_en.
- WAIT: count SLIP_WAIT cycles, then go to CHECK with match_cnt = 0.
- CHECK: compare the lane word with TRAIN_PATTERN every cycle.
  - On a match, match_cnt++. On the LOCK_COUNT-th consecutive match, go to LOCKED.
  - On a mismatch, go to FAIL if slip_cnt == MAX_SLIPS; otherwise go to SLIP.
- SLIP: alignwd = 1 for exactly this one cycle; slip_cnt++; go to WAIT.
- LOCKED: locked = 1. The lane holds lock regardless of data or train_en level; there is no lock-loss detection.
- FAIL: fail = 1; no further alignwd pulses are issued.
- Priority, highest first, applied in any state:
  1. ready_in low forces IDLE and clears locked, fail and slip_cnt.
  2. A train_en rising edge (registered edge detect) with ready_in high forces WAIT and clears slip_cnt, match_cnt, locked and fail.
- slip_cnt saturates at MAX_SLIPS.
- data_out updates every cycle regardless of lock.
- data_valid = registered (all_locked && !train_en), aligned with data_out.
- Reset values: every output is 0 and every FSM is in IDLE.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- data_out latency is 1 cycle from q_in.
- Edge 0 samples ready_in && train_en (steady high) → WAIT from cycle 1.
- CHECK starts at cycle 1+SLIP_WAIT.
- With zero slips, locked rises at cycle 1+SLIP_WAIT+LOCK_COUNT; this is 25 with defaults.
- Each slip adds SLIP_WAIT+2 cycles. Minimum alignwd spacing is SLIP_WAIT+2 cycles.
- alignwd is never wider than 1 cycle.
- ready_in deasserting mid-SLIP drops alignwd on the next cycle.
- all_locked follows locked with zero added latency, because it is the AND of the registered bits.
- A train_en edge and a match on the same cycle: the restart wins.

## Structure
- Shared package `iddr_align_pkg` holds:
  - the lane state enum (6 states);
  - the function computing SW;
  - default constants for SLIP_WAIT and LOCK_COUNT.
- Sub-module `iddr_align_lane`: one FSM with its counters, instantiated CHANNELS times by generate.
- The top level holds:
  - the train_en edge detector;
  - the data_out register;
  - the all_locked / data_valid logic.

## Test plan
- Reset: hold reset_n low with random inputs → all outputs 0. Release with ready_in = 0 → lanes remain IDLE and alignwd stays 0.
- Pre-aligned lanes: q_in lanes = 4'hC constantly; assert ready_in and train_en at cycle 0 → locked = 4'hF at cycle 25, slip_count = 0, no alignwd pulses.
- Misaligned lane: gearbox model rotates lane 2 by one bit per alignwd and starts 2 bits off → exactly 2 alignwd pulses on lane 2, spaced 10 cycles → lane 2 locked with slip_count = 2.
- No pattern: lane 1 receives 4'h0 permanently → exactly 8 alignwd pulses, then fail[1] = 1, all_locked = 0, no further pulses. Re-pulse train_en → fail clears and slip_count = 0.
- Mid-training drop: deassert ready_in during CHECK → next cycle locked = 0, fail = 0, alignwd = 0. Reassert ready_in → training repeats from WAIT.
- Data mode: all lanes locked, then drop train_en → data_valid = 1 one cycle later; data_out equals q_in delayed 1 cycle for a random stream.
